// File: rtl/mem_pkg.sv
// mem_pkg: request/response payloads and requester ids shared by the memory arbiter
package mem_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
  } mem_req_t;
  typedef struct packed {
    logic [31:0] rdata;
  } mem_resp_t;
  typedef enum logic {REQ_IF = 1'b0, REQ_LS = 1'b1} req_id_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: decoupled valid/ready channel carrying a payload of type T
interface mem_arbiter_if #(parameter type T = logic);
  T     data;
  logic valid;
  logic ready;
  modport master (output data, output valid, input ready);
  modport slave (input data, input valid, output ready);
endinterface

// File: rtl/tag_fifo.sv
// tag_fifo: in-order tag queue with registered write and combinational head read
module tag_fifo
  import mem_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = req_id_e
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  T                       din,
  output T                       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  T r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [PW:0] r_cnt;
  logic w_wr, w_rd;
  assign empty = r_cnt == '0;
  assign full = r_cnt == (PW+1)'(DEPTH);
  assign count = r_cnt;
  assign dout = r_mem[r_rd];
  assign w_wr = push && !full;
  assign w_rd = pop && !empty;
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr] <= din;
  // power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      r_wr <= r_wr + PW'(w_wr);
      r_rd <= r_rd + PW'(w_rd);
      r_cnt <= r_cnt + (PW+1)'(w_wr) - (PW+1)'(w_rd);
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one memory port between IF and LS, responses steered in issue order
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  mem_arbiter_if.slave                      if_req,
  mem_arbiter_if.slave                      ls_req,
  mem_arbiter_if.master                     if_resp,
  mem_arbiter_if.master                     ls_resp,
  mem_arbiter_if.master                     mem_req,
  mem_arbiter_if.slave                      mem_resp,
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
  output logic                              err_orphan
);
  req_id_e r_last, r_lock_id, w_grant, w_head;
  logic r_lock, w_can_issue, w_push, w_pop, w_empty, w_full, w_rsp_v;
  // a pop in the same cycle never frees a slot for issue: can_issue looks only at the registered count
  assign w_can_issue = !w_full;
  assign w_grant = r_lock ? r_lock_id :
                   (if_req.valid && ls_req.valid) ? (r_last == REQ_IF ? REQ_LS : REQ_IF) :
                   (ls_req.valid ? REQ_LS : REQ_IF);
  assign mem_req.valid = w_can_issue && (w_grant == REQ_LS ? ls_req.valid : if_req.valid);
  assign mem_req.data = w_grant == REQ_LS ? ls_req.data : if_req.data;
  assign if_req.ready = w_can_issue && mem_req.ready && w_grant == REQ_IF;
  assign ls_req.ready = w_can_issue && mem_req.ready && w_grant == REQ_LS;
  assign w_push = mem_req.valid && mem_req.ready;
  assign w_rsp_v = mem_resp.valid && !w_empty;
  assign if_resp.valid = w_rsp_v && w_head == REQ_IF;
  assign ls_resp.valid = w_rsp_v && w_head == REQ_LS;
  assign if_resp.data = mem_resp.data;
  assign ls_resp.data = mem_resp.data;
  assign mem_resp.ready = !w_empty && (w_head == REQ_LS ? ls_resp.ready : if_resp.ready);
  assign w_pop = mem_resp.valid && mem_resp.ready;
  tag_fifo #(.DEPTH(MAX_OUTSTANDING), .T(req_id_e)) u_tags (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_grant),
    .dout  (w_head),
    .empty (w_empty),
    .full  (w_full),
    .count (outstanding)
  );
  // a stalled offer locks the grant so the request seen by memory cannot change
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_last <= REQ_LS;
      r_lock <= 1'b0;
      r_lock_id <= REQ_IF;
      err_orphan <= 1'b0;
    end else begin
      if (w_push) begin
        r_last <= w_grant;
        r_lock <= 1'b0;
      end else if (mem_req.valid) begin
        r_lock <= 1'b1;
        r_lock_id <= w_grant;
      end
      if (mem_resp.valid && w_empty) err_orphan <= 1'b1;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scenario tasks checked against a queue-based model of the arbiter
module tb_mem_arbiter;
  import mem_pkg::*;
  localparam int MAX = 4;
  localparam int OW = $clog2(MAX) + 1;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  mem_arbiter_if #(.T(mem_req_t)) if_req();
  mem_arbiter_if #(.T(mem_req_t)) ls_req();
  mem_arbiter_if #(.T(mem_req_t)) mem_req();
  mem_arbiter_if #(.T(mem_resp_t)) if_resp();
  mem_arbiter_if #(.T(mem_resp_t)) ls_resp();
  mem_arbiter_if #(.T(mem_resp_t)) mem_resp();
  logic [OW-1:0] outstanding;
  logic err_orphan;
  mem_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .ls_req(ls_req), .if_resp(if_resp), .ls_resp(ls_resp),
    .mem_req(mem_req), .mem_resp(mem_resp), .outstanding(outstanding), .err_orphan(err_orphan)
  );
  int n_vec = 0, n_err = 0;
  bit q[$];
  bit m_last, m_lock, m_lock_id, m_orphan;
  bit a_mrdy, a_rspv;
  logic [31:0] a_rspd;
  bit e_g, e_mv, e_ifr, e_lsr, e_ifrv, e_lsrv, e_mrr;
  mem_req_t e_md;

  function automatic mem_req_t rnd_req();
    return '{addr: $urandom, wdata: $urandom, we: 1'($urandom), be: 4'($urandom)};
  endfunction

  task automatic m_reset();
    q.delete();
    m_last = 1'b1;
    m_lock = 1'b0;
    m_orphan = 1'b0;
  endtask

  task automatic apply(bit ifv, bit lsv, mem_req_t ifd, mem_req_t lsd, bit mrdy, bit rspv,
                       logic [31:0] rspd, bit ifrr, bit lsrr);
    if_req.valid = ifv; if_req.data = ifd;
    ls_req.valid = lsv; ls_req.data = lsd;
    mem_req.ready = mrdy;
    mem_resp.valid = rspv; mem_resp.data = rspd;
    if_resp.ready = ifrr; ls_resp.ready = lsrr;
    a_mrdy = mrdy; a_rspv = rspv; a_rspd = rspd;
    #1;
    e_g = m_lock ? m_lock_id : (ifv && lsv) ? !m_last : lsv;
    e_mv = (q.size() < MAX) && (e_g ? lsv : ifv);
    e_md = e_g ? lsd : ifd;
    e_ifr = (q.size() < MAX) && mrdy && !e_g;
    e_lsr = (q.size() < MAX) && mrdy && e_g;
    e_ifrv = rspv && q.size() > 0 && q[0] == 1'b0;
    e_lsrv = rspv && q.size() > 0 && q[0] == 1'b1;
    e_mrr = q.size() > 0 && (q[0] ? lsrr : ifrr);
  endtask

  task automatic advance();
    if (a_rspv && q.size() == 0) m_orphan = 1'b1;
    if (a_rspv && e_mrr) void'(q.pop_front());
    if (e_mv && a_mrdy) begin
      q.push_back(e_g);
      m_last = e_g;
      m_lock = 1'b0;
    end else if (e_mv) begin
      m_lock = 1'b1;
      m_lock_id = e_g;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 16 && q.size() > 0; i++) begin
      apply(0, 0, '0, '0, 0, 1, $urandom, 1, 1);
      advance();
    end
  endtask

  task automatic test_reset();
    apply(0, 0, '0, '0, 0, 0, 0, 0, 0);
    n_vec++; if ({mem_req.valid, if_resp.valid, ls_resp.valid} !== 3'b000) begin n_err++; $display("FAIL reset valids: got %b want 000", {mem_req.valid, if_resp.valid, ls_resp.valid}); end
    n_vec++; if ({if_req.ready, ls_req.ready, mem_resp.ready} !== 3'b000) begin n_err++; $display("FAIL reset readies: got %b want 000", {if_req.ready, ls_req.ready, mem_resp.ready}); end
    n_vec++; if ({outstanding, err_orphan} !== '0) begin n_err++; $display("FAIL reset occ/err: got %0d/%b want 0/0", outstanding, err_orphan); end
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_single_if();
    mem_req_t d = '{addr: 32'h100, wdata: $urandom, we: 1'b0, be: 4'hf};
    apply(1, 0, d, rnd_req(), 1, 0, 0, 0, 0);
    n_vec++; if (mem_req.valid !== 1'b1 || mem_req.data !== d) begin n_err++; $display("FAIL single pass-through: got v=%b addr=%h want v=1 addr=100", mem_req.valid, mem_req.data.addr); end
    n_vec++; if ({if_req.ready, ls_req.ready} !== 2'b10) begin n_err++; $display("FAIL single readies: got %b want 10", {if_req.ready, ls_req.ready}); end
    advance();
    apply(0, 0, d, '0, 1, 1, 32'hDEADBEEF, 1, 1);
    n_vec++; if (outstanding !== OW'(1)) begin n_err++; $display("FAIL single occupancy: got %0d want 1", outstanding); end
    n_vec++; if ({if_resp.valid, ls_resp.valid} !== 2'b10 || if_resp.data.rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL single resp: got v=%b d=%h want 10 deadbeef", {if_resp.valid, ls_resp.valid}, if_resp.data.rdata); end
    n_vec++; if (mem_resp.ready !== 1'b1) begin n_err++; $display("FAIL single mem_resp.ready: got %b want 1", mem_resp.ready); end
    advance();
    apply(0, 0, '0, '0, 0, 0, 0, 0, 0);
    n_vec++; if (outstanding !== OW'(0)) begin n_err++; $display("FAIL single drained: got %0d want 0", outstanding); end
  endtask

  task automatic test_alternate();
    bit exp_id = !m_last;
    bit prev_id = 1'b0;
    mem_req_t ifd, lsd;
    logic [31:0] rd;
    for (int i = 0; i < 12; i++) begin
      ifd = rnd_req(); lsd = rnd_req(); rd = $urandom;
      apply(1, 1, ifd, lsd, 1, i > 0, rd, 1, 1);
      n_vec++; if (mem_req.valid !== 1'b1 || mem_req.data !== (exp_id ? lsd : ifd)) begin n_err++; $display("FAIL alt grant cyc %0d: got v=%b addr=%h want id %0d addr=%h", i, mem_req.valid, mem_req.data.addr, exp_id, exp_id ? lsd.addr : ifd.addr); end
      if (i > 0) begin
        n_vec++; if ({if_resp.valid, ls_resp.valid} !== (prev_id ? 2'b01 : 2'b10)) begin n_err++; $display("FAIL alt resp route cyc %0d: got %b want id %0d", i, {if_resp.valid, ls_resp.valid}, prev_id); end
        n_vec++; if ((prev_id ? ls_resp.data.rdata : if_resp.data.rdata) !== rd) begin n_err++; $display("FAIL alt resp data cyc %0d: want %h", i, rd); end
      end
      prev_id = exp_id;
      exp_id = !exp_id;
      advance();
    end
    drain();
  endtask

  task automatic test_stall();
    mem_req_t ifd = rnd_req(), lsd = rnd_req();
    apply(0, 1, '0, lsd, 1, 0, 0, 0, 0);
    advance();
    drain();
    for (int i = 0; i < 3; i++) begin
      apply(1, 1, ifd, lsd, 0, 0, 0, 0, 0);
      n_vec++; if (mem_req.valid !== 1'b1 || mem_req.data !== ifd) begin n_err++; $display("FAIL stall hold IF cyc %0d: got v=%b addr=%h want 1 %h", i, mem_req.valid, mem_req.data.addr, ifd.addr); end
      n_vec++; if ({if_req.ready, ls_req.ready} !== 2'b00) begin n_err++; $display("FAIL stall readies cyc %0d: got %b want 00", i, {if_req.ready, ls_req.ready}); end
      advance();
    end
    apply(1, 1, ifd, lsd, 1, 0, 0, 0, 0);
    n_vec++; if (if_req.ready !== 1'b1 || mem_req.data !== ifd) begin n_err++; $display("FAIL stall release: got rdy=%b addr=%h want 1 %h", if_req.ready, mem_req.data.addr, ifd.addr); end
    advance();
    ifd = rnd_req();
    apply(1, 1, ifd, lsd, 1, 0, 0, 0, 0);
    n_vec++; if (ls_req.ready !== 1'b1 || mem_req.data !== lsd) begin n_err++; $display("FAIL stall next LS: got rdy=%b addr=%h want 1 %h", ls_req.ready, mem_req.data.addr, lsd.addr); end
    advance();
    drain();
    lsd = rnd_req();
    apply(0, 1, ifd, lsd, 0, 0, 0, 0, 0);
    advance();
    for (int i = 0; i < 2; i++) begin
      apply(1, 1, ifd, lsd, 0, 0, 0, 0, 0);
      n_vec++; if (mem_req.valid !== 1'b1 || mem_req.data !== lsd) begin n_err++; $display("FAIL lock keeps LS cyc %0d: got addr=%h want %h", i, mem_req.data.addr, lsd.addr); end
      advance();
    end
    apply(1, 1, ifd, lsd, 1, 0, 0, 0, 0);
    n_vec++; if ({if_req.ready, ls_req.ready} !== 2'b01) begin n_err++; $display("FAIL lock release readies: got %b want 01", {if_req.ready, ls_req.ready}); end
    advance();
    apply(1, 1, ifd, rnd_req(), 1, 0, 0, 0, 0);
    n_vec++; if (mem_req.data !== ifd) begin n_err++; $display("FAIL lock then IF: got addr=%h want %h", mem_req.data.addr, ifd.addr); end
    advance();
    drain();
  endtask

  task automatic test_full();
    mem_req_t d;
    for (int i = 0; i < MAX; i++) begin
      apply(1, 0, rnd_req(), '0, 1, 0, 0, 0, 0);
      n_vec++; if (mem_req.valid !== 1'b1) begin n_err++; $display("FAIL full fill %0d: got v=%b want 1", i, mem_req.valid); end
      advance();
    end
    d = rnd_req();
    apply(1, 0, d, '0, 1, 0, 0, 0, 0);
    n_vec++; if (outstanding !== OW'(MAX) || mem_req.valid !== 1'b0 || if_req.ready !== 1'b0) begin n_err++; $display("FAIL full stall: got occ=%0d v=%b rdy=%b want %0d 0 0", outstanding, mem_req.valid, if_req.ready, MAX); end
    advance();
    apply(1, 0, d, '0, 1, 1, $urandom, 1, 1);
    n_vec++; if (mem_resp.ready !== 1'b1 || if_resp.valid !== 1'b1 || mem_req.valid !== 1'b0) begin n_err++; $display("FAIL full pop cycle: got mrr=%b ifv=%b mv=%b want 1 1 0", mem_resp.ready, if_resp.valid, mem_req.valid); end
    advance();
    apply(1, 0, d, '0, 1, 0, 0, 0, 0);
    n_vec++; if (outstanding !== OW'(MAX - 1) || mem_req.valid !== 1'b1 || mem_req.data !== d) begin n_err++; $display("FAIL full reissue: got occ=%0d v=%b want %0d 1", outstanding, mem_req.valid, MAX - 1); end
    advance();
    drain();
  endtask

  task automatic test_wrap();
    bit id;
    mem_req_t d;
    for (int i = 0; i < 2; i++) begin
      apply(0, 1, '0, rnd_req(), 1, 0, 0, 0, 0);
      advance();
    end
    for (int i = 0; i < 8; i++) begin
      id = 1'($urandom);
      d = rnd_req();
      apply(!id, id, d, d, 1, 1, $urandom, 1, 1);
      n_vec++; if (outstanding !== OW'(2) || mem_req.valid !== 1'b1 || mem_resp.ready !== 1'b1) begin n_err++; $display("FAIL wrap cyc %0d: got occ=%0d mv=%b mrr=%b want 2 1 1", i, outstanding, mem_req.valid, mem_resp.ready); end
      n_vec++; if ({if_resp.valid, ls_resp.valid} !== (q[0] ? 2'b01 : 2'b10)) begin n_err++; $display("FAIL wrap route cyc %0d: got %b want id %0d", i, {if_resp.valid, ls_resp.valid}, q[0]); end
      advance();
    end
    apply(0, 0, '0, '0, 0, 0, 0, 0, 0);
    n_vec++; if (outstanding !== OW'(2)) begin n_err++; $display("FAIL wrap final occ: got %0d want 2", outstanding); end
    drain();
  endtask

  task automatic test_random();
    bit ifv = 1'b0, lsv = 1'b0;
    mem_req_t ifd = rnd_req(), lsd = rnd_req();
    for (int i = 0; i < 300; i++) begin
      if (!(m_lock && !m_lock_id)) begin ifv = 1'($urandom); ifd = rnd_req(); end
      if (!(m_lock && m_lock_id)) begin lsv = 1'($urandom); lsd = rnd_req(); end
      apply(ifv, lsv, ifd, lsd, $urandom_range(0, 3) != 0, q.size() > 0 && 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
      n_vec++; if (mem_req.valid !== e_mv) begin n_err++; $display("FAIL rnd mem_req.valid cyc %0d: got %b want %b", i, mem_req.valid, e_mv); end
      if (e_mv) begin n_vec++; if (mem_req.data !== e_md) begin n_err++; $display("FAIL rnd mem_req.data cyc %0d: got addr=%h want %h", i, mem_req.data.addr, e_md.addr); end end
      n_vec++; if ({if_req.ready, ls_req.ready} !== {e_ifr, e_lsr}) begin n_err++; $display("FAIL rnd req readies cyc %0d: got %b want %b", i, {if_req.ready, ls_req.ready}, {e_ifr, e_lsr}); end
      n_vec++; if ({if_resp.valid, ls_resp.valid} !== {e_ifrv, e_lsrv}) begin n_err++; $display("FAIL rnd resp valids cyc %0d: got %b want %b", i, {if_resp.valid, ls_resp.valid}, {e_ifrv, e_lsrv}); end
      if (e_ifrv || e_lsrv) begin n_vec++; if ((e_ifrv ? if_resp.data.rdata : ls_resp.data.rdata) !== a_rspd) begin n_err++; $display("FAIL rnd resp data cyc %0d: want %h", i, a_rspd); end end
      n_vec++; if (mem_resp.ready !== e_mrr) begin n_err++; $display("FAIL rnd mem_resp.ready cyc %0d: got %b want %b", i, mem_resp.ready, e_mrr); end
      n_vec++; if (outstanding !== OW'(q.size()) || err_orphan !== m_orphan) begin n_err++; $display("FAIL rnd occ/err cyc %0d: got %0d/%b want %0d/%b", i, outstanding, err_orphan, q.size(), m_orphan); end
      advance();
    end
    drain();
  endtask

  task automatic test_orphan();
    apply(0, 0, '0, '0, 0, 1, $urandom, 1, 1);
    n_vec++; if ({mem_resp.ready, if_resp.valid, ls_resp.valid, err_orphan} !== 4'b0000) begin n_err++; $display("FAIL orphan cycle: got %b want 0000", {mem_resp.ready, if_resp.valid, ls_resp.valid, err_orphan}); end
    advance();
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, '0, '0, 0, 0, 0, 0, 0);
      n_vec++; if (err_orphan !== 1'b1) begin n_err++; $display("FAIL orphan sticky %0d: got %b want 1", i, err_orphan); end
      advance();
    end
    for (int i = 0; i < 2; i++) begin
      apply(1, 1, rnd_req(), rnd_req(), 1, 0, 0, 0, 0);
      advance();
    end
    apply(1, 1, rnd_req(), rnd_req(), 1, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    n_vec++; if (outstanding !== OW'(0) || err_orphan !== 1'b0) begin n_err++; $display("FAIL async reset: got occ=%0d err=%b want 0 0", outstanding, err_orphan); end
    apply(0, 0, '0, '0, 0, 0, 0, 0, 0);
    n_vec++; if ({mem_req.valid, if_req.ready, ls_req.ready, if_resp.valid, ls_resp.valid, mem_resp.ready} !== 6'b0) begin n_err++; $display("FAIL reset outputs: got %b want 000000", {mem_req.valid, if_req.ready, ls_req.ready, if_resp.valid, ls_resp.valid, mem_resp.ready}); end
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    apply(0, 0, '0, '0, 0, 1, $urandom, 1, 1);
    n_vec++; if (mem_resp.ready !== 1'b0) begin n_err++; $display("FAIL late orphan ready: got %b want 0", mem_resp.ready); end
    advance();
    apply(0, 0, '0, '0, 0, 0, 0, 0, 0);
    n_vec++; if (err_orphan !== 1'b1) begin n_err++; $display("FAIL late orphan flag: got %b want 1", err_orphan); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    m_reset();
    test_reset();
    test_single_if();
    test_alternate();
    test_stall();
    test_full();
    test_wrap();
    test_random();
    test_orphan();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
